fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin arbiter sharing the single write port of the async FIFO (fifo2) among NREQ producers.
//   Sits in the write-clock domain: grants one requester at a time for a burst of up to BURST words.
//   Drives fifo2 wdata/winc directly and back-pressures requesters from wfull.
// PARAMETERS
//   DSIZE  8  data width; matches fifo2 DSIZE
//   NREQ   4  number of requesters, 2..16
//   BURST  4  max words per grant, 1..256
//   IDW    $clog2(NREQ)  (localparam) grant index width
// PORTS
//   wclk       in   1           write-domain clock, rising edge
//   wrst       in   1           async reset, active-high; clears all state immediately
//   req_valid  in   NREQ        bit i: requester i has a word on req_data slice i
//   req_data   in   NREQ*DSIZE  slice i = req_data[i*DSIZE +: DSIZE]
//   req_ready  out  NREQ        bit i: word from requester i accepted this cycle if valid
//   wfull      in   1           fifo2 full flag (already in wclk domain)
//   wdata      out  DSIZE       to fifo2 wdata
//   winc       out  1           to fifo2 winc; one word written per wclk edge while high
//   grant_id   out  IDW         index of current/last granted requester
//   busy       out  1           high while in GRANT state
// BEHAVIOUR
//   Reset (wrst=1, async): state=IDLE, grant_id=0, rr_ptr=NREQ-1 (so req 0 has first priority),
//     beat_cnt=0, busy=0; winc=0, req_ready=0, wdata=0 (combinational, follow state).
//   FSM states: IDLE, GRANT.
//   IDLE: if |req_valid, pick first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ;
//     register grant_id, beat_cnt=0, go GRANT. Arbitration latency: 1 wclk, no write in IDLE.
//     If no valid, stay IDLE.
//   GRANT (g=grant_id): req_ready[g] = ~wfull; all other req_ready bits 0.
//     winc = req_valid[g] & ~wfull; wdata = req_data slice g (0 when winc=0).
//     Transfer = winc. On transfer beat_cnt++.
//   GRANT exit -> IDLE, rr_ptr<=g, when either:
//     a) transfer and beat_cnt==BURST-1 (burst complete), or
//     b) req_valid[g]==0 (requester idle; no write that cycle).
//   wfull stall: req_valid[g]=1 & wfull=1 -> hold GRANT, no winc, beat_cnt unchanged, no timeout.
//   Requesters may change valid/data only after a ready handshake or while valid=0; arbiter never
//     drops a word: a word is written iff req_valid[g] & req_ready[g] at the wclk edge.
//   Min gap between bursts: 1 IDLE cycle. Max throughput: BURST words per BURST+1 cycles.
//   Fairness: requester that just finished has lowest priority next IDLE; worst-case wait for
//     a continuously valid requester = (NREQ-1)*(BURST+1) cycles excluding wfull stalls.
//   beat_cnt width $clog2(BURST)+1; never exceeds BURST-1 on a transfer; wraps never (reset on grant).
//   winc never asserted while wfull=1 (no overflow writes into fifo2).
//   Reset mid-burst: outputs drop same cycle; after release next grant goes to req 0 if valid.
// TESTING
//   T1 single req: only req 2 valid, data 0x10..0x15, wfull=0 -> grant_id=2, winc 4 cycles
//      (0x10..0x13), 1 IDLE cycle, then 0x14,0x15; fifo2 reads back 0x10..0x15 in order.
//   T2 all valid after reset -> grant order 0,1,2,3,0; each burst exactly 4 winc pulses;
//      req_ready only on granted bit; 16 words in 20 cycles.
//   T3 wfull stall: req 1 granted, wfull forced 1 after 2 beats for 5 cycles -> winc=0,
//      req_ready[1]=0, grant held; on wfull=0 remaining 2 beats written, no loss/dup.
//   T4 early release: req 3 drops valid after 1 beat, req 0 valid -> GRANT->IDLE, rr_ptr=3,
//      next grant_id=0; req 3 wrote exactly 1 word.
//   T5 reset mid-burst: assert wrst during beat 2 of req 1 -> winc/req_ready/busy 0 same
//      cycle; after release with reqs 1 and 2 valid, first grant_id=1 (req 0 not valid, ptr=3).
//   T6 end-to-end with fifo2 (ASIZE=6, wclk 12.5ns, rclk 20ns): 4 reqs x 30 words each,
//      reader drains -> 120 words read, per-requester order preserved, wfull never overflowed.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single fifo2 write port among NREQ producers.
// Grants one requester at a time for bursts of up to BURST words, stalls on wfull.
module fifo_wr_arbiter #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic [DSIZE-1:0]      wdata,
  output logic                  winc,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(BURST) + 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state, state_d;
  logic [IDW-1:0]  grant_d;
  logic [IDW-1:0]  rr_ptr, rr_d;
  logic [CW-1:0]   beat_cnt, beat_d;
  logic [IDW-1:0]  pick;
  logic            pick_found;

  // Round-robin search starting just after the last served requester
  always_comb begin
    int idx;
    logic [IDW-1:0] idx_w;
    pick_found = 1'b0;
    pick       = '0;
    idx        = 0;
    idx_w      = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      idx_w = IDW'(idx);
      if (!pick_found && req_valid[idx_w]) begin
        pick_found = 1'b1;
        pick       = idx_w;
      end
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= IDW'(NREQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      grant_id <= grant_d;
      rr_ptr   <= rr_d;
      beat_cnt <= beat_d;
    end
  end

  // Next state plus the write-port outputs, which follow the registered state
  always_comb begin
    state_d   = state;
    grant_d   = grant_id;
    rr_d      = rr_ptr;
    beat_d    = beat_cnt;
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_id] = ~wfull;
        if (req_valid[grant_id] && !wfull) begin
          winc   = 1'b1;
          wdata  = req_data[int'(grant_id)*int'(DSIZE) +: DSIZE];
          beat_d = beat_cnt + CW'(1);
          if (beat_cnt == CW'(BURST - 1)) begin
            state_d = IDLE;
            rr_d    = grant_id;
          end
        end else if (!req_valid[grant_id]) begin
          state_d = IDLE;
          rr_d    = grant_id;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: producer queues feed a per-requester
// scoreboard, a small fifo occupancy model supplies wfull for the end-to-end run.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic [7:0]  wdata;
  logic        winc;
  logic [1:0]  grant_id;
  logic        busy;

  fifo_wr_arbiter #(.DSIZE(8), .NREQ(4), .BURST(4)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .wdata(wdata), .winc(winc),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 wclk = ~wclk;

  logic [7:0]  src [4][$];
  logic [7:0]  expq[4][$];
  logic [1:0]  glog[$];
  logic [3:0]  en;
  logic        full_force;
  logic        use_fifo;
  logic        prev_busy;
  logic [63:0] wtr;
  int          fifo_cnt;
  int          fifo_depth;
  int          winc_cnt[4];
  int          checks   = 0;
  int          failures = 0;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] first;
    logic [1:0] second;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = en[i] && (src[i].size() > 0);
      req_data[i*8 +: 8] = (src[i].size() > 0) ? src[i][0] : 8'h00;
    end
    wfull = full_force || (use_fifo && fifo_cnt >= fifo_depth);
  endtask

  task automatic load(input int r, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      src[r].push_back(base + 8'(k));
      expq[r].push_back(base + 8'(k));
    end
  endtask

  // One wclk: monitor at negedge, handshake bookkeeping and new drive after posedge
  task automatic cycle();
    logic [3:0] hs;
    @(negedge wclk);
    wtr = {wtr[62:0], winc};
    if (winc) begin
      check("no_overflow_wfull", 32'(wfull), 0);
      check("ready_on_write", 32'(req_ready[grant_id]), 1);
      if (expq[grant_id].size() == 0) check("unexpected_word", 32'(wdata), 32'hFFFF_FFFF);
      else check("wdata", 32'(wdata), 32'(expq[grant_id].pop_front()));
      winc_cnt[grant_id]++;
      if (use_fifo) fifo_cnt++;
    end
    if (busy) check("ready_only_granted", 32'(req_ready & ~(4'b0001 << grant_id)), 0);
    hs = req_valid & req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) void'(src[i].pop_front());
    if (use_fifo && fifo_cnt > 0 && $urandom_range(0, 99) < 60) fifo_cnt--;
    if (busy && !prev_busy) glog.push_back(grant_id);
    prev_busy = busy;
    drive_inputs();
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src[i].delete();
      expq[i].delete();
      winc_cnt[i] = 0;
    end
    glog.delete();
    en = 4'b0; full_force = 1'b0; use_fifo = 1'b0; fifo_cnt = 0;
    prev_busy = 1'b0; wtr = '0;
    drive_inputs();
    #1;
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_winc", 32'(winc), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_wdata", 32'(wdata), 0);
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    #1;
  endtask

  task automatic all_drained(input string name);
    for (int i = 0; i < 4; i++) check(name, 32'(expq[i].size()), 0);
  endtask

  initial begin
    vecs[0] = '{4'b1111, 2'd0, 2'd1};
    vecs[1] = '{4'b1001, 2'd0, 2'd3};
    vecs[2] = '{4'b0001, 2'd0, 2'd0};
    vecs[3] = '{4'b1100, 2'd2, 2'd3};
    vecs[4] = '{4'b0100, 2'd2, 2'd2};
    vecs[5] = '{4'b1010, 2'd1, 2'd3};
    fifo_depth = 64;
    req_valid = '0; req_data = '0; wfull = 1'b0; wrst = 1'b1;

    // Arbitration table: first grant after reset and the grant after one full burst
    foreach (vecs[v]) begin
      do_reset();
      for (int i = 0; i < 4; i++) if (vecs[v].mask[i]) load(i, 8'(8'h40 + i*16), 6);
      en = vecs[v].mask;
      drive_inputs();
      cycle();
      check("tbl_first_grant", 32'(grant_id), 32'(vecs[v].first));
      check("tbl_busy", 32'(busy), 1);
      run(5);
      check("tbl_burst_len", 32'(winc_cnt[vecs[v].first]), 4);
      check("tbl_grants", 32'(glog.size()), 2);
      if (glog.size() >= 2) check("tbl_second_grant", 32'(glog[1]), 32'(vecs[v].second));
    end

    // Single requester 2 with six words: 4-beat burst, one idle cycle, 2 more beats
    do_reset();
    load(2, 8'h10, 6);
    en = 4'b0100;
    drive_inputs();
    cycle();
    check("t1_grant", 32'(grant_id), 2);
    run(11);
    check("t1_winc_trace", 32'(wtr[11:0]), 32'b0111_1011_0000);
    check("t1_count", 32'(winc_cnt[2]), 6);
    all_drained("t1_drained");

    // All requesters valid: grant order 0,1,2,3,0 and 16 words in 20 cycles
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 8'(8'h80 + i*16), 8);
    en = 4'b1111;
    drive_inputs();
    run(20);
    check("t2_trace", 32'(wtr[19:0]), 32'b0111_1011_1101_1110_1111);
    run(1);
    check("t2_grants", 32'(glog.size()), 5);
    for (int k = 0; k < 5 && k < glog.size(); k++) check("t2_order", 32'(glog[k]), 32'(k % 4));

    // wfull stall after two beats, held for 5 cycles
    do_reset();
    load(1, 8'h20, 4);
    en = 4'b0010;
    drive_inputs();
    run(3);
    check("t3_beats_before", 32'(winc_cnt[1]), 2);
    full_force = 1'b1;
    drive_inputs();
    #1;
    for (int k = 0; k < 5; k++) begin
      check("t3_stall_winc", 32'(winc), 0);
      check("t3_stall_ready", 32'(req_ready), 0);
      check("t3_stall_hold", 32'({busy, grant_id}), 32'({1'b1, 2'd1}));
      cycle();
    end
    full_force = 1'b0;
    drive_inputs();
    run(4);
    check("t3_total", 32'(winc_cnt[1]), 4);
    all_drained("t3_drained");

    // Early release: req 3 has one word, then req 0 gets the next grant
    do_reset();
    load(3, 8'h30, 1);
    load(0, 8'h00, 2);
    en = 4'b1000;
    drive_inputs();
    cycle();
    check("t4_grant3", 32'(grant_id), 3);
    en = 4'b1001;
    drive_inputs();
    run(2);
    check("t4_released", 32'(busy), 0);
    cycle();
    check("t4_next_grant", 32'(grant_id), 0);
    run(4);
    check("t4_req3_words", 32'(winc_cnt[3]), 1);
    check("t4_req0_words", 32'(winc_cnt[0]), 2);

    // Reset during beat 2 of req 1; pointer returns to 3 so req 1 wins over req 2
    do_reset();
    load(1, 8'h50, 4);
    en = 4'b0010;
    drive_inputs();
    run(2);
    check("t5_mid_burst_winc", 32'(winc), 1);
    wrst = 1'b1;
    #1;
    check("t5_rst_winc", 32'(winc), 0);
    check("t5_rst_ready", 32'(req_ready), 0);
    check("t5_rst_busy", 32'(busy), 0);
    #1;
    wrst = 1'b0;
    load(2, 8'h60, 2);
    en = 4'b0110;
    drive_inputs();
    cycle();
    check("t5_first_grant", 32'(grant_id), 1);
    run(12);
    all_drained("t5_drained");

    // End-to-end: 4 x 30 words into a shallow fifo model drained at a slower rate
    do_reset();
    fifo_depth = 8;
    use_fifo = 1'b1;
    for (int i = 0; i < 4; i++) load(i, 8'(i*64), 30);
    en = 4'b1111;
    drive_inputs();
    for (int k = 0; k < 2000; k++) begin
      if (expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size() == 0) break;
      cycle();
    end
    check("t6_total", 32'(winc_cnt[0] + winc_cnt[1] + winc_cnt[2] + winc_cnt[3]), 120);
    all_drained("t6_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
